// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares one memory bus between an instruction-fetch port (i_*) and a
// load/store data port (d_*). One transaction is in flight at a time. When
// both ports request in the same IDLE cycle, the port that did not win last
// time is granted (round-robin). The bus request is registered. Completion is
// reported to the winning port combinationally in the cycle memory answers. A
// transaction that memory has not answered within TIMEOUT_CYCLES BUSY cycles
// completes with a fault and a zero read value.
//
// Ports:
//   clk, reset                    clock, synchronous active-high reset
//   i_valid_in, i_address_in      fetch request and address
//   i_ready_out                   fetch completion strobe (one cycle)
//   i_read_value_out, i_fault_out fetch result, valid with i_ready_out
//   d_valid_in, d_address_in      data request and address
//   d_write_mask_in               byte write enables, 0 = read
//   d_write_value_in              store data
//   d_ready_out                   data completion strobe (one cycle)
//   d_read_value_out, d_fault_out data result, valid with d_ready_out
//   mem_valid_out .. mem_write_value_out  registered bus request/payload
//   mem_ready_in, mem_read_value_in       memory completion and read data
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 256,
   parameter int unsigned TIMER_WIDTH    = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_valid_in,
   input  logic [31:0] i_address_in,
   output logic        i_ready_out,
   output logic [31:0] i_read_value_out,
   output logic        i_fault_out,
   input  logic        d_valid_in,
   input  logic [31:0] d_address_in,
   input  logic [3:0]  d_write_mask_in,
   input  logic [31:0] d_write_value_in,
   output logic        d_ready_out,
   output logic [31:0] d_read_value_out,
   output logic        d_fault_out,
   output logic        mem_valid_out,
   output logic [31:0] mem_address_out,
   output logic [3:0]  mem_write_mask_out,
   output logic [31:0] mem_write_value_out,
   input  logic        mem_ready_in,
   input  logic [31:0] mem_read_value_in
);

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   // Timer value seen in the last BUSY cycle before a timeout fires.
   localparam logic [TIMER_WIDTH-1:0] TIMER_LAST =
      (TIMEOUT_CYCLES == 0) ? '0 : TIMER_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [TIMER_WIDTH-1:0] TIMER_MAX = '1;

   state_t                 state, state_next;
   logic                   last_grant_d, last_grant_d_next;  // 1 = D won last
   logic [TIMER_WIDTH-1:0] timer;

   logic grant_i, grant_d;
   logic busy, timeout_hit, done, fault;

   // Arbitration and completion decode.
   always_comb begin
      busy        = (state != IDLE);
      timeout_hit = (TIMEOUT_CYCLES != 0) && (timer == TIMER_LAST);
      // A memory answer in the timeout cycle wins over the fault.
      done        = busy && (mem_ready_in || timeout_hit);
      fault       = busy && !mem_ready_in && timeout_hit;
      grant_d     = (state == IDLE) && d_valid_in && (!i_valid_in || !last_grant_d);
      grant_i     = (state == IDLE) && i_valid_in && (!d_valid_in ||  last_grant_d);
   end

   // Per-port results. The losing port sees raw memory data so it is never X.
   always_comb begin
      i_ready_out      = (state == BUSY_I) && done;
      i_fault_out      = (state == BUSY_I) && fault;
      i_read_value_out = i_fault_out ? 32'h0 : mem_read_value_in;
      d_ready_out      = (state == BUSY_D) && done;
      d_fault_out      = (state == BUSY_D) && fault;
      d_read_value_out = d_fault_out ? 32'h0 : mem_read_value_in;
   end

   // NOTE: every signal written here gets a default first, so no path through
   // the case can leave one unassigned and infer a latch.
   always_comb begin
      state_next        = state;
      last_grant_d_next = last_grant_d;
      case (state)
         IDLE: begin
            if (grant_d) begin
               state_next        = BUSY_D;
               last_grant_d_next = 1'b1;
            end else if (grant_i) begin
               state_next        = BUSY_I;
               last_grant_d_next = 1'b0;
            end
         end
         BUSY_I, BUSY_D: begin
            if (done) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // values from before the edge, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         last_grant_d <= 1'b0;  // I counts as last winner, so D wins first tie
      end else begin
         state        <= state_next;
         last_grant_d <= last_grant_d_next;
      end
   end

   // Bus request registers and timeout counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_valid_out       <= 1'b0;
         mem_address_out     <= 32'h0;
         mem_write_mask_out  <= 4'h0;
         mem_write_value_out <= 32'h0;
         timer               <= '0;
      end else if (grant_d) begin
         mem_valid_out       <= 1'b1;
         mem_address_out     <= d_address_in;
         mem_write_mask_out  <= d_write_mask_in;
         mem_write_value_out <= d_write_value_in;
         timer               <= '0;
      end else if (grant_i) begin
         mem_valid_out       <= 1'b1;
         mem_address_out     <= i_address_in;
         mem_write_mask_out  <= 4'h0;   // fetches never write
         mem_write_value_out <= 32'h0;
         timer               <= '0;
      end else if (busy) begin
         if (done) begin
            mem_valid_out <= 1'b0;
         end else if (timer != TIMER_MAX) begin
            timer <= timer + 1'b1;      // saturate rather than wrap
         end
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_arbiter
//
// Self-checking bench for mem_bus_arbiter built with TIMEOUT_CYCLES = 4.
// Inputs are driven on the falling edge and outputs are sampled 1 ns later.
// Expected values come from a transaction-level model: which port wins, how
// many BUSY cycles a transaction lasts (min of memory latency and timeout)
// and whether it faults.
// -----------------------------------------------------------------------------
module tb_mem_bus_arbiter;

   localparam int TIMEOUT = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        i_valid_in;
   logic [31:0] i_address_in;
   logic        i_ready_out;
   logic [31:0] i_read_value_out;
   logic        i_fault_out;
   logic        d_valid_in;
   logic [31:0] d_address_in;
   logic [3:0]  d_write_mask_in;
   logic [31:0] d_write_value_in;
   logic        d_ready_out;
   logic [31:0] d_read_value_out;
   logic        d_fault_out;
   logic        mem_valid_out;
   logic [31:0] mem_address_out;
   logic [3:0]  mem_write_mask_out;
   logic [31:0] mem_write_value_out;
   logic        mem_ready_in;
   logic [31:0] mem_read_value_in;

   int tests_run = 0;
   int tests_failed = 0;

   // {i_ready, i_fault, d_ready, d_fault}
   logic [3:0] status;
   assign status = {i_ready_out, i_fault_out, d_ready_out, d_fault_out};

   always #5 clk = ~clk;

   mem_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .TIMER_WIDTH(16)) dut (
      .clk                 (clk),
      .reset               (reset),
      .i_valid_in          (i_valid_in),
      .i_address_in        (i_address_in),
      .i_ready_out         (i_ready_out),
      .i_read_value_out    (i_read_value_out),
      .i_fault_out         (i_fault_out),
      .d_valid_in          (d_valid_in),
      .d_address_in        (d_address_in),
      .d_write_mask_in     (d_write_mask_in),
      .d_write_value_in    (d_write_value_in),
      .d_ready_out         (d_ready_out),
      .d_read_value_out    (d_read_value_out),
      .d_fault_out         (d_fault_out),
      .mem_valid_out       (mem_valid_out),
      .mem_address_out     (mem_address_out),
      .mem_write_mask_out  (mem_write_mask_out),
      .mem_write_value_out (mem_write_value_out),
      .mem_ready_in        (mem_ready_in),
      .mem_read_value_in   (mem_read_value_in)
   );

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      i_valid_in = 1'b0; i_address_in = '0;
      d_valid_in = 1'b0; d_address_in = '0; d_write_mask_in = '0; d_write_value_in = '0;
      mem_ready_in = 1'b0; mem_read_value_in = '0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Runs the BUSY phase of one transaction whose IDLE request cycle has
   // already been driven. lat = BUSY cycle in which memory answers (0 = never).
   // Ends in the following IDLE cycle, optionally dropping the winner's valid.
   task automatic expect_txn(input string name, input bit win_d, input int lat,
                             input logic [31:0] rdata, input logic [31:0] exp_addr,
                             input logic [3:0] exp_mask, input logic [31:0] exp_wval,
                             input bit drop);
      int fin;
      bit flt;
      logic [3:0] exp_status;
      logic [31:0] win_val, lose_val;
      flt = (lat == 0) || (lat > TIMEOUT);
      fin = flt ? TIMEOUT : lat;
      for (int k = 1; k <= fin; k++) begin
         @(negedge clk);
         mem_ready_in = (k == lat);
         mem_read_value_in = rdata;
         #1;
         if (k == 1) begin
            tests_run++;
            if ({mem_valid_out, mem_address_out, mem_write_mask_out, mem_write_value_out}
                !== {1'b1, exp_addr, exp_mask, exp_wval}) begin
               tests_failed++;
               $display("FAIL %s bus_req: got v=%b a=%h m=%h w=%h want v=1 a=%h m=%h w=%h",
                        name, mem_valid_out, mem_address_out, mem_write_mask_out,
                        mem_write_value_out, exp_addr, exp_mask, exp_wval);
            end
         end
         exp_status = 4'b0000;
         if (k == fin) exp_status = win_d ? {2'b00, 1'b1, flt} : {1'b1, flt, 2'b00};
         tests_run++;
         if (status !== exp_status) begin
            tests_failed++;
            $display("FAIL %s status cyc%0d: got %b want %b", name, k, status, exp_status);
         end
         if (k == fin) begin
            win_val  = win_d ? d_read_value_out : i_read_value_out;
            lose_val = win_d ? i_read_value_out : d_read_value_out;
            tests_run++;
            if ({win_val, lose_val} !== {(flt ? 32'h0 : rdata), rdata}) begin
               tests_failed++;
               $display("FAIL %s rdata: got win=%h lose=%h want win=%h lose=%h",
                        name, win_val, lose_val, (flt ? 32'h0 : rdata), rdata);
            end
         end
      end
      @(negedge clk);
      mem_ready_in = 1'b0;
      if (drop) begin
         if (win_d) d_valid_in = 1'b0; else i_valid_in = 1'b0;
      end
      #1;
      tests_run++;
      if ({mem_valid_out, status} !== 5'b0) begin
         tests_failed++;
         $display("FAIL %s back_to_idle: got v=%b st=%b want 0", name, mem_valid_out, status);
      end
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      tests_run++;
      if ({mem_valid_out, mem_address_out, mem_write_mask_out, mem_write_value_out, status} !== '0) begin
         tests_failed++;
         $display("FAIL reset_outputs: got v=%b a=%h m=%h w=%h st=%b want all 0",
                  mem_valid_out, mem_address_out, mem_write_mask_out, mem_write_value_out, status);
      end
      tests_run++;
      if ($isunknown({i_read_value_out, d_read_value_out})) begin
         tests_failed++;
         $display("FAIL reset_rdata_x: got i=%h d=%h want known", i_read_value_out, d_read_value_out);
      end
   endtask

   task automatic test_single_write();
      do_reset();
      d_valid_in = 1'b1; d_address_in = 32'h100; d_write_mask_in = 4'hF;
      d_write_value_in = 32'hDEADBEEF;
      #1;
      tests_run++;
      if ({mem_valid_out, status} !== 5'b0) begin
         tests_failed++;
         $display("FAIL write_req_cycle: got v=%b st=%b want 0", mem_valid_out, status);
      end
      expect_txn("single_write", 1'b1, 3, 32'h0BADF00D, 32'h100, 4'hF, 32'hDEADBEEF, 1'b1);
   endtask

   task automatic test_round_robin();
      do_reset();
      i_valid_in = 1'b1; i_address_in = 32'h2000;
      d_valid_in = 1'b1; d_address_in = 32'h300; d_write_mask_in = 4'h3;
      d_write_value_in = 32'h11112222;
      expect_txn("rr_first_d", 1'b1, 1, 32'hAAAA5555, 32'h300, 4'h3, 32'h11112222, 1'b0);
      d_address_in = 32'h304; d_write_mask_in = 4'h0; d_write_value_in = 32'h0;
      expect_txn("rr_then_i", 1'b0, 1, 32'h00000013, 32'h2000, 4'h0, 32'h0, 1'b0);
      i_address_in = 32'h2004;
      expect_txn("rr_then_d", 1'b1, 2, 32'h5A5A5A5A, 32'h304, 4'h0, 32'h0, 1'b1);
      i_valid_in = 1'b0;
   endtask

   task automatic test_timeout();
      do_reset();
      i_valid_in = 1'b1; i_address_in = 32'h4000;
      expect_txn("timeout_fault", 1'b0, 0, 32'hFFFF0000, 32'h4000, 4'h0, 32'h0, 1'b1);
   endtask

   task automatic test_timeout_tie();
      do_reset();
      i_valid_in = 1'b1; i_address_in = 32'h4010;
      expect_txn("timeout_tie", 1'b0, TIMEOUT, 32'hCAFEF00D, 32'h4010, 4'h0, 32'h0, 1'b1);
   endtask

   task automatic test_reset_in_busy();
      do_reset();
      d_valid_in = 1'b1; d_address_in = 32'h500; d_write_mask_in = 4'h1;
      d_write_value_in = 32'h77;
      @(negedge clk);                      // BUSY_D cycle 1
      #1;
      tests_run++;
      if (mem_valid_out !== 1'b1) begin
         tests_failed++;
         $display("FAIL rst_busy_started: got v=%b want 1", mem_valid_out);
      end
      @(negedge clk);                      // BUSY_D cycle 2, reset applied
      reset = 1'b1;
      #1;
      tests_run++;
      if (status !== 4'b0) begin
         tests_failed++;
         $display("FAIL rst_busy_no_ready: got st=%b want 0000", status);
      end
      @(negedge clk);
      reset = 1'b0; d_valid_in = 1'b0;
      mem_ready_in = 1'b1; mem_read_value_in = 32'h12345678;  // late answer
      #1;
      tests_run++;
      if ({mem_valid_out, mem_address_out, mem_write_mask_out, mem_write_value_out, status} !== '0) begin
         tests_failed++;
         $display("FAIL rst_busy_cleared: got v=%b a=%h m=%h w=%h st=%b want all 0",
                  mem_valid_out, mem_address_out, mem_write_mask_out, mem_write_value_out, status);
      end
      @(negedge clk);
      mem_ready_in = 1'b0;
      i_valid_in = 1'b1; i_address_in = 32'h6000;
      d_valid_in = 1'b1; d_address_in = 32'h600; d_write_mask_in = 4'h0;
      d_write_value_in = 32'h0;
      expect_txn("rst_busy_d_first", 1'b1, 1, 32'h600D600D, 32'h600, 4'h0, 32'h0, 1'b1);
      expect_txn("rst_busy_i_next", 1'b0, 1, 32'h00000013, 32'h6000, 4'h0, 32'h0, 1'b1);
   endtask

   task automatic test_idle_ready();
      do_reset();
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         mem_ready_in = 1'b1; mem_read_value_in = $urandom;
         #1;
         tests_run++;
         if ({mem_valid_out, status} !== 5'b0) begin
            tests_failed++;
            $display("FAIL idle_stray_ready%0d: got v=%b st=%b want 0", c, mem_valid_out, status);
         end
      end
      @(negedge clk);
      d_valid_in = 1'b1; d_address_in = 32'h700; d_write_mask_in = 4'h8;
      d_write_value_in = 32'h89ABCDEF;     // mem_ready_in still 1 in this IDLE cycle
      #1;
      tests_run++;
      if ({mem_valid_out, status} !== 5'b0) begin
         tests_failed++;
         $display("FAIL idle_ready_with_req: got v=%b st=%b want 0", mem_valid_out, status);
      end
      expect_txn("idle_ready_txn", 1'b1, 2, 32'h31415926, 32'h700, 4'h8, 32'h89ABCDEF, 1'b1);
   endtask

   // Randomized traffic against a transaction-level model.
   task automatic test_random();
      bit pend_i, pend_d, model_last_d, win_d;
      logic [31:0] ia, da, dv;
      logic [3:0] dm;
      do_reset();
      pend_i = 0; pend_d = 0; model_last_d = 0;
      for (int t = 0; t < 40; t++) begin
         if (!pend_i && $urandom_range(0, 1) == 1) begin
            pend_i = 1; ia = $urandom;
         end
         if (!pend_d && $urandom_range(0, 1) == 1) begin
            pend_d = 1; da = $urandom; dm = 4'($urandom); dv = $urandom;
         end
         if (!pend_i && !pend_d) begin
            pend_d = 1; da = $urandom; dm = 4'($urandom); dv = $urandom;
         end
         i_valid_in = pend_i; i_address_in = ia;
         d_valid_in = pend_d; d_address_in = da; d_write_mask_in = dm; d_write_value_in = dv;
         win_d = (pend_i && pend_d) ? !model_last_d : pend_d;
         model_last_d = win_d;
         if (win_d) begin
            expect_txn("random_d", 1'b1, $urandom_range(0, 6), $urandom, da, dm, dv, 1'b1);
            pend_d = 0;
         end else begin
            expect_txn("random_i", 1'b0, $urandom_range(0, 6), $urandom, ia, 4'h0, 32'h0, 1'b1);
            pend_i = 0;
         end
      end
      i_valid_in = 1'b0; d_valid_in = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      test_reset();
      test_single_write();
      test_round_robin();
      test_timeout();
      test_timeout_tie();
      test_reset_in_busy();
      test_idle_ready();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
